// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode/funct encodings and ALU operation type for the MIPS-subset core
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational 32-bit ALU; zero flag drives the BEQ decision
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] y,
    output logic        zero
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
            default: y = '0;
        endcase
    end

    assign zero = (y == 32'd0);

endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - single-cycle MIPS-subset core with loadable instruction memory
module cpu
    import cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        initialize,
    input  logic [31:0] instruction_initialize_data,
    input  logic [31:0] instruction_initialize_address
);

    localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] imem    [0:IMEM_WORDS-1];
    logic [31:0] dmem    [0:DMEM_WORDS-1];
    logic [31:0] regfile [0:31];
    logic [31:0] pc;

    logic [29:0] w_init_idx;
    logic        w_init_in_range;
    logic [29:0] w_fetch_idx;
    logic        w_fetch_in_range;
    logic [31:0] w_instr;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_simm;
    logic [25:0] w_target;

    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;

    alu_op_t     w_alu_op;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_y;
    logic        w_alu_zero;
    logic        w_reg_we;
    logic [4:0]  w_wr_reg;
    logic        w_mem_to_reg;
    logic        w_mem_we;
    logic        w_branch;
    logic        w_jump;

    logic [29:0] w_dmem_idx;
    logic        w_dmem_in_range;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_pc_next;

    // Instruction load port deliberately ignores rst so a program can be loaded while the core is held.
    assign w_init_idx      = instruction_initialize_address[31:2];
    assign w_init_in_range = ({2'b00, w_init_idx} < 32'(IMEM_WORDS));

    always_ff @(posedge clk) begin
        if (initialize && w_init_in_range) begin
            imem[w_init_idx[IAW-1:0]] <= instruction_initialize_data;
        end
    end

    assign w_fetch_idx      = pc[31:2];
    assign w_fetch_in_range = ({2'b00, w_fetch_idx} < 32'(IMEM_WORDS));
    assign w_instr          = w_fetch_in_range ? imem[w_fetch_idx[IAW-1:0]] : 32'd0;

    assign w_opcode = w_instr[31:26];
    assign w_rs     = w_instr[25:21];
    assign w_rt     = w_instr[20:16];
    assign w_rd     = w_instr[15:11];
    assign w_funct  = w_instr[5:0];
    assign w_simm   = sign_ext16(w_instr[15:0]);
    assign w_target = w_instr[25:0];

    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : regfile[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : regfile[w_rt];

    always_comb begin
        w_alu_op     = ALU_ADD;
        w_alu_b      = w_rt_val;
        w_reg_we     = 1'b0;
        w_wr_reg     = w_rd;
        w_mem_to_reg = 1'b0;
        w_mem_we     = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_reg_we = 1'b1;
                case (w_funct)
                    F_ADD:   w_alu_op = ALU_ADD;
                    F_SUB:   w_alu_op = ALU_SUB;
                    F_AND:   w_alu_op = ALU_AND;
                    F_OR:    w_alu_op = ALU_OR;
                    F_SLT:   w_alu_op = ALU_SLT;
                    default: w_reg_we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                w_alu_b  = w_simm;
                w_reg_we = 1'b1;
                w_wr_reg = w_rt;
            end
            OP_LW: begin
                w_alu_b      = w_simm;
                w_reg_we     = 1'b1;
                w_wr_reg     = w_rt;
                w_mem_to_reg = 1'b1;
            end
            OP_SW: begin
                w_alu_b  = w_simm;
                w_mem_we = 1'b1;
            end
            OP_BEQ: begin
                w_alu_op = ALU_SUB;
                w_branch = 1'b1;
            end
            OP_J: begin
                w_jump = 1'b1;
            end
            default: begin
            end
        endcase
    end

    cpu_alu u_alu (
        .a    (w_rs_val),
        .b    (w_alu_b),
        .op   (w_alu_op),
        .y    (w_alu_y),
        .zero (w_alu_zero)
    );

    assign w_dmem_idx      = w_alu_y[31:2];
    assign w_dmem_in_range = ({2'b00, w_dmem_idx} < 32'(DMEM_WORDS));
    assign w_load_data     = w_dmem_in_range ? dmem[w_dmem_idx[DAW-1:0]] : 32'd0;
    assign w_wb_data       = w_mem_to_reg ? w_load_data : w_alu_y;

    assign w_pc_plus4      = pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + {w_simm[29:0], 2'b00};
    assign w_jump_target   = {w_pc_plus4[31:28], w_target, 2'b00};

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_jump) begin
            w_pc_next = w_jump_target;
        end else if (w_branch && w_alu_zero) begin
            w_pc_next = w_branch_target;
        end
    end

    // Reset preloads regfile[k] = k so programs have distinct operands without setup code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= 32'd0;
            for (int k = 0; k < 32; k++) begin
                regfile[k] <= 32'(k);
            end
            for (int k = 0; k < DMEM_WORDS; k++) begin
                dmem[k] <= 32'd0;
            end
        end else if (!initialize) begin
            pc <= w_pc_next;
            if (w_reg_we && (w_wr_reg != 5'd0)) begin
                regfile[w_wr_reg] <= w_wb_data;
            end
            if (w_mem_we && w_dmem_in_range) begin
                dmem[w_dmem_idx[DAW-1:0]] <= w_rt_val;
            end
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, pc[1:0], w_instr[10:6], w_alu_y[1:0],
                        instruction_initialize_address[1:0]};

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - scoreboard bench: expected architectural state per retired instruction
module tb_cpu;
    import cpu_pkg::*;

    localparam int K_REG = 0;
    localparam int K_PC  = 1;
    localparam int K_MEM = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        initialize = 1'b0;
    logic [31:0] init_data = 32'd0;
    logic [31:0] init_addr = 32'd0;

    cpu #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .initialize                     (initialize),
        .instruction_initialize_data    (init_data),
        .instruction_initialize_address (init_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        int          kind;
        int          addr;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   retired = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) retired <= 0;
        else if (!initialize) retired <= retired + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] probe(input int kind, input int addr);
        case (kind)
            K_REG:   return dut.regfile[addr];
            K_PC:    return dut.pc;
            default: return dut.dmem[addr];
        endcase
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {OP_J, t};
    endfunction

    task automatic expect_at(input int idx, input int kind, input int addr, input logic [31:0] val);
        exp_t e;
        e.idx = idx; e.kind = kind; e.addr = addr; e.val = val;
        sb.push_back(e);
    endtask

    // All stimulus tasks start and end at negedge+2 so they never race the monitor.
    task automatic write_imem(input logic [31:0] a, input logic [31:0] d);
        init_addr  = a;
        init_data  = d;
        initialize = 1'b1;
        @(negedge clk);
        #2;
        initialize = 1'b0;
    endtask

    task automatic run(input int n);
        rst = 1'b0;
        repeat (n) @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && retired > 0 && sb[0].idx <= retired) begin
                e = sb.pop_front();
                check($sformatf("retire%0d kind%0d addr%0d", e.idx, e.kind, e.addr),
                      probe(e.kind, e.addr), e.val);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] w0;
        repeat (2) @(negedge clk);
        #2;
        check("reset_pc", dut.pc, 32'd0);
        check("reset_r0", dut.regfile[0], 32'd0);
        check("reset_r31", dut.regfile[31], 32'd31);
        check("reset_dmem5", dut.dmem[5], 32'd0);

        // Basic ADD/SLT sequence, plus an out-of-range load that must not alias imem[0]
        w0 = enc_r(5'd0, 5'd2, 5'd1, F_ADD);
        write_imem(32'h00, w0);
        write_imem(32'h04, enc_r(5'd1, 5'd2, 5'd1, F_ADD));
        write_imem(32'h08, enc_r(5'd1, 5'd2, 5'd3, F_SLT));
        write_imem(32'h0C, enc_r(5'd2, 5'd1, 5'd3, F_SLT));
        write_imem(32'h100, 32'hDEADBEEF);
        check("imem0_no_alias", dut.imem[0], w0);
        expect_at(1, K_REG, 1, 32'd2);
        expect_at(1, K_PC, 0, 32'h4);
        expect_at(2, K_REG, 1, 32'd4);
        expect_at(3, K_REG, 3, 32'd0);
        expect_at(4, K_REG, 3, 32'd1);
        expect_at(4, K_PC, 0, 32'h10);
        run(4);

        // Signed compare, SUB/AND/OR, R0 write discard, unknown funct, read-before-write
        write_imem(32'h00, enc_i(OP_ADDI, 5'd0, 5'd4, 16'hFFFF));
        write_imem(32'h04, enc_r(5'd4, 5'd1, 5'd5, F_SLT));
        write_imem(32'h08, enc_r(5'd1, 5'd4, 5'd5, F_SLT));
        write_imem(32'h0C, enc_r(5'd1, 5'd2, 5'd0, F_ADD));
        write_imem(32'h10, enc_r(5'd1, 5'd2, 5'd6, F_SUB));
        write_imem(32'h14, enc_r(5'd7, 5'd11, 5'd10, F_AND));
        write_imem(32'h18, enc_r(5'd12, 5'd3, 5'd12, F_OR));
        write_imem(32'h1C, enc_r(5'd1, 5'd2, 5'd13, 6'h27));
        write_imem(32'h20, enc_r(5'd1, 5'd1, 5'd1, F_ADD));
        expect_at(1, K_REG, 4, 32'hFFFFFFFF);
        expect_at(2, K_REG, 5, 32'd1);
        expect_at(3, K_REG, 5, 32'd0);
        expect_at(4, K_REG, 0, 32'd0);
        expect_at(5, K_REG, 6, 32'hFFFFFFFF);
        expect_at(6, K_REG, 10, 32'd3);
        expect_at(7, K_REG, 12, 32'd15);
        expect_at(8, K_REG, 13, 32'd13);
        expect_at(8, K_PC, 0, 32'h20);
        expect_at(9, K_REG, 1, 32'd2);
        run(9);

        // Loads/stores including negative offset and out-of-range accesses
        write_imem(32'h00, enc_i(OP_SW, 5'd0, 5'd7, 16'h0008));
        write_imem(32'h04, enc_i(OP_LW, 5'd0, 5'd9, 16'h0008));
        write_imem(32'h08, enc_i(OP_SW, 5'd8, 5'd7, 16'hFFFC));
        write_imem(32'h0C, enc_i(OP_LW, 5'd0, 5'd10, 16'h0100));
        write_imem(32'h10, enc_i(OP_SW, 5'd0, 5'd31, 16'h0100));
        write_imem(32'h14, enc_i(OP_LW, 5'd0, 5'd11, 16'h0004));
        expect_at(1, K_MEM, 2, 32'd7);
        expect_at(2, K_REG, 9, 32'd7);
        expect_at(3, K_MEM, 1, 32'd7);
        expect_at(4, K_REG, 10, 32'd0);
        expect_at(5, K_MEM, 0, 32'd0);
        expect_at(6, K_REG, 11, 32'd7);
        run(6);
        @(negedge clk);
        #2;
        check("reset_clears_dmem2", dut.dmem[2], 32'd0);

        // Taken/not-taken/backward branches, jump, unknown opcode
        write_imem(32'h00, enc_i(OP_ADDI, 5'd20, 5'd20, 16'h0001));
        write_imem(32'h04, enc_i(OP_ADDI, 5'd20, 5'd20, 16'h0001));
        write_imem(32'h08, enc_i(OP_ADDI, 5'd20, 5'd20, 16'h0001));
        write_imem(32'h0C, enc_i(OP_ADDI, 5'd20, 5'd20, 16'h0001));
        write_imem(32'h10, enc_i(OP_BEQ, 5'd1, 5'd1, 16'h0002));
        write_imem(32'h14, enc_i(OP_ADDI, 5'd21, 5'd21, 16'h0001));
        write_imem(32'h18, enc_i(OP_ADDI, 5'd21, 5'd21, 16'h0001));
        write_imem(32'h1C, enc_j(26'h10));
        write_imem(32'h3C, enc_i(6'h3F, 5'd1, 5'd2, 16'h0000));
        write_imem(32'h40, enc_i(OP_BEQ, 5'd1, 5'd2, 16'h0005));
        write_imem(32'h44, enc_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFD));
        expect_at(4, K_REG, 20, 32'd24);
        expect_at(4, K_PC, 0, 32'h10);
        expect_at(5, K_PC, 0, 32'h1C);
        expect_at(6, K_PC, 0, 32'h40);
        expect_at(7, K_PC, 0, 32'h44);
        expect_at(8, K_PC, 0, 32'h3C);
        expect_at(9, K_PC, 0, 32'h40);
        expect_at(9, K_REG, 2, 32'd2);
        expect_at(9, K_REG, 21, 32'd21);
        expect_at(9, K_MEM, 0, 32'd0);
        run(9);

        write_imem(32'h10, enc_i(OP_BEQ, 5'd1, 5'd2, 16'h0002));
        expect_at(5, K_PC, 0, 32'h14);
        run(5);

        // Asynchronous reset mid-run, then execution held by initialize
        w0 = enc_i(OP_ADDI, 5'd0, 5'd5, 16'd100);
        write_imem(32'h00, w0);
        write_imem(32'h04, enc_i(OP_ADDI, 5'd0, 5'd6, 16'd200));
        write_imem(32'h08, enc_i(OP_ADDI, 5'd0, 5'd7, 16'd300));
        expect_at(1, K_REG, 5, 32'd100);
        expect_at(2, K_REG, 6, 32'd200);
        expect_at(2, K_PC, 0, 32'h8);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #0.5;
        check("async_rst_pc", dut.pc, 32'd0);
        check("async_rst_r5", dut.regfile[5], 32'd5);
        check("async_rst_r6", dut.regfile[6], 32'd6);
        check("async_rst_imem0", dut.imem[0], w0);
        #0.5;
        rst = 1'b0;
        expect_at(1, K_REG, 5, 32'd100);
        expect_at(1, K_PC, 0, 32'h4);
        @(negedge clk);
        #2;
        init_addr  = 32'h50;
        init_data  = 32'd0;
        initialize = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("hold_pc", dut.pc, 32'h4);
        check("hold_r6", dut.regfile[6], 32'd6);
        initialize = 1'b0;
        expect_at(2, K_REG, 6, 32'd200);
        expect_at(2, K_PC, 0, 32'h8);
        @(negedge clk);
        #2;
        rst = 1'b1;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL unchecked retire%0d kind%0d addr%0d actual=none required=0x%08h",
                     e.idx, e.kind, e.addr, e.val);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
